// File: rtl/y_chunk_adder_if.sv
// rtl/y_chunk_adder_if.sv - start/done handshake and operand/result bundle for y_chunk_adder
// The sub signal exists only when Y_CHUNK_ADDER_SUB_EN is defined.
interface y_chunk_adder_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef Y_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
`ifdef Y_CHUNK_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, z, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
`ifdef Y_CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, z, cout, ovf
  );
endinterface

// File: rtl/y_chunk_adder.sv
// rtl/y_chunk_adder.sv - multi-cycle ripple adder, CHUNK bits per clock with a registered carry
// Optional subtract mode (a + ~b + 1) is enabled by defining Y_CHUNK_ADDER_SUB_EN.
module y_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic             clk,
  input logic             reset,
  y_chunk_adder_if.slave  bus
);
  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [IDXW-1:0]            idx;
  logic                       carry;
  logic [N-1:0][CHUNK-1:0]    a_r;
  logic [N-1:0][CHUNK-1:0]    b_r;
  logic [N-1:0][CHUNK-1:0]    z_r;
  logic                       cout_r;
  logic                       ovf_r;

  logic                       accept;
  logic                       go;
  logic                       last;
  logic [CHUNK-1:0]           a_c;
  logic [CHUNK-1:0]           b_c;
  logic [CHUNK:0]             chunk_sum;
  logic                       msb_cin;

  assign accept = (state == IDLE) || (state == DONE);
  assign go     = accept && bus.start;
  assign last   = (idx == IDXW'(N - 1));

  assign a_c       = a_r[idx];
  assign b_c       = b_r[idx];
  assign chunk_sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};
  // Carry into the top bit of the chunk, recovered from its sum bit.
  assign msb_cin   = chunk_sum[CHUNK-1] ^ a_c[CHUNK-1] ^ b_c[CHUNK-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      b_r    <= '0;
      z_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (go) begin
      a_r    <= bus.a;
`ifdef Y_CHUNK_ADDER_SUB_EN
      // Subtraction folds into the add path: invert b and force the carry-in.
      b_r    <= bus.sub ? ~bus.b : bus.b;
      carry  <= bus.sub | bus.cin;
`else
      b_r    <= bus.b;
      carry  <= bus.cin;
`endif
      z_r    <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      idx    <= '0;
    end else if (state == RUN) begin
      z_r[idx] <= chunk_sum[CHUNK-1:0];
      carry    <= chunk_sum[CHUNK];
      idx      <= idx + 1'b1;
      if (last) begin
        cout_r <= chunk_sum[CHUNK];
        ovf_r  <= msb_cin ^ chunk_sum[CHUNK];
      end
    end
  end

  assign bus.z    = z_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_y_chunk_adder.sv
// tb/tb_y_chunk_adder.sv - randomized and directed bench for y_chunk_adder against an arithmetic model
// Exercises subtract mode as well when Y_CHUNK_ADDER_SUB_EN is defined.
module tb_y_chunk_adder;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  y_chunk_adder_if #(.WIDTH(WIDTH)) bus ();

  y_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, z} from plain wide arithmetic and the signed-overflow rule.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic sub);
    logic [31:0] bb;
    logic        c;
    logic [32:0] full;
    logic        ov;
    bb   = sub ? ~b : b;
    c    = sub ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, bb} + {32'd0, c};
    ov   = (a[31] == bb[31]) && (full[31] != a[31]);
    return {ov, full[32], full[31:0]};
  endfunction

  // Issues one start at the current (negedge) time and follows it to done.
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                    input logic sub, input bit pulse_mid, output logic [33:0] e);
    int ncyc;
    int nbusy;
    bit seen;
    e = model(a, b, cin, sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef Y_CHUNK_ADDER_SUB_EN
    bus.sub = sub;
`endif
    bus.start = 1'b1;
    ncyc  = 0;
    nbusy = 0;
    seen  = 0;
    while (!seen && ncyc < 20) begin
      @(negedge clk);
      ncyc++;
      if (ncyc == 1) begin
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.cin   = 1'($urandom);
        check("clear_on_start", {30'd0, bus.z, bus.cout, bus.ovf}, 64'd0);
      end
      if (pulse_mid && ncyc == 2) begin
        bus.start = 1'b1;
        bus.a     = 32'h11111111;
      end
      if (pulse_mid && ncyc == 3) bus.start = 1'b0;
      if (bus.done) seen = 1;
      else if (bus.busy) nbusy++;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(ncyc), 64'(N + 1));
    check("busy_cycles", 64'(nbusy), 64'(N));
    check("z", 64'(bus.z), 64'(e[31:0]));
    check("cout", 64'(bus.cout), 64'(e[32]));
    check("ovf", 64'(bus.ovf), 64'(e[33]));
  endtask

  initial begin
    logic [33:0] e;
    logic [31:0] ra, rb;
    logic        rs;
    int          idle;
    int          dones;
    logic [31:0] pats [5];

    checks   = 0;
    failures = 0;
    pats[0] = 32'hFFFFFFFF;
    pats[1] = 32'h80000000;
    pats[2] = 32'h7FFFFFFF;
    pats[3] = 32'h00000000;
    pats[4] = 32'h00000001;

    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = 32'h5;
    bus.b     = 32'h6;
    bus.cin   = 1'b0;
`ifdef Y_CHUNK_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_outs", {30'd0, bus.z, bus.cout, bus.ovf}, 64'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(negedge clk);

    op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, e);
    check("ripple_z", 64'(bus.z), 64'h0);
    check("ripple_cout", 64'(bus.cout), 64'd1);
    @(negedge clk);
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, e);
    check("ovf_pos", {31'd0, bus.ovf, bus.z}, {31'd0, 1'b1, 32'h80000000});
    @(negedge clk);
    op(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, e);
    check("ovf_neg", {30'd0, bus.ovf, bus.cout, bus.z}, {30'd0, 2'b11, 32'h0});
    @(negedge clk);
    op(32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b0, e);
    check("cin_chunk", 64'(bus.z), 64'h100);
    @(negedge clk);
    op(32'h00000001, 32'h00000002, 1'b0, 1'b0, 1'b1, e);
    check("ignore_mid_start", 64'(bus.z), 64'h3);
    op(32'h00000002, 32'h00000003, 1'b0, 1'b0, 1'b0, e);
    check("back_to_back", 64'(bus.z), 64'h5);
`ifdef Y_CHUNK_ADDER_SUB_EN
    @(negedge clk);
    op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, e);
    check("sub_neg", {30'd0, bus.ovf, bus.cout, bus.z}, {30'd0, 2'b00, 32'hFFFFFFFE});
    @(negedge clk);
    op(32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0, e);
    check("sub_ovf", {30'd0, bus.ovf, bus.cout, bus.z}, {30'd0, 2'b11, 32'h7FFFFFFF});
`endif

    // Reset during RUN must abort without a done pulse.
    @(negedge clk);
    bus.a     = 32'hFFFFFFFF;
    bus.b     = 32'h00000001;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_outs", {29'd0, bus.done, bus.z, bus.cout, bus.ovf}, 64'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    op(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, e);
    check("after_abort", 64'(bus.z), 64'h2);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 4)] : 32'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 4)] : 32'($urandom);
`ifdef Y_CHUNK_ADDER_SUB_EN
      rs = 1'($urandom);
`else
      rs = 1'b0;
`endif
      op(ra, rb, 1'($urandom), rs, bit'($urandom_range(0, 3) == 0), e);
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) begin
        @(negedge clk);
        check("hold", {30'd0, bus.done, bus.ovf, bus.cout, bus.z},
              {30'd0, 1'b0, e[33], e[32], e[31:0]});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
